// File: rtl/ultrasonic_echo_capture.sv
// ultrasonic_echo_capture
// Fires the ultrasonic sensor trigger once per measurement period, times the
// returning echo pulse in centimetre units and publishes an 8-bit distance
// with a one-clock calculate strobe for the downstream divider/display chain.
// Optional build macro: ECHO_DEGLITCH_EN adds a 4-sample debounce filter on
// the synchronized echo (rejects pulses shorter than 4 clocks).
module ultrasonic_echo_capture #(
  parameter int TRIG_CLKS    = 500,
  parameter int CM_CLKS      = 2900,
  parameter int TIMEOUT_CLKS = 1_500_000,
  parameter int PERIOD_CLKS  = 3_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       echo,
  output logic       trigger,
  output logic [7:0] count,
  output logic       calculate,
  output logic       timeout,
  output logic       busy
);

  localparam int PW = (PERIOD_CLKS  > 1) ? $clog2(PERIOD_CLKS)  : 1;
  localparam int TW = (TRIG_CLKS    > 1) ? $clog2(TRIG_CLKS)    : 1;
  localparam int WW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int CW = (CM_CLKS      > 1) ? $clog2(CM_CLKS)      : 1;

  localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CLKS - 1);
  localparam logic [TW-1:0] TRIG_LAST    = TW'(TRIG_CLKS - 1);
  localparam logic [WW-1:0] TIMEOUT_LAST = WW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] CM_LAST      = CW'(CM_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TRIG = 3'd1,
    ST_WAIT = 3'd2,
    ST_MEAS = 3'd3,
    ST_DONE = 3'd4,
    ST_PUB  = 3'd5
  } state_t;

  state_t          state_r, state_n;
  logic            sync_m_r, sync_q_r;
  logic            echo_s, echo_p;
  logic            echo_rise, echo_fall;
  logic [PW-1:0]   period_r;
  logic [TW-1:0]   trig_cnt_r;
  logic [WW-1:0]   wait_cnt_r;
  logic [CW-1:0]   tick_r;
  logic [7:0]      unit_r;
  logic            tflag_r;
  logic            period_end;

  // Two-flop synchronizer for the asynchronous echo input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_m_r <= 1'b0;
      sync_q_r <= 1'b0;
    end else begin
      sync_m_r <= echo;
      sync_q_r <= sync_m_r;
    end
  end

`ifdef ECHO_DEGLITCH_EN
  logic       filt_r;
  logic [1:0] filt_cnt_r;

  // Debounce: the filtered level follows only after 4 consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_r     <= 1'b0;
      filt_cnt_r <= 2'd0;
    end else if (sync_q_r != filt_r) begin
      if (filt_cnt_r == 2'd3) begin
        filt_r     <= sync_q_r;
        filt_cnt_r <= 2'd0;
      end else begin
        filt_cnt_r <= filt_cnt_r + 2'd1;
      end
    end else begin
      filt_cnt_r <= 2'd0;
    end
  end

  assign echo_s = filt_r;
`else
  assign echo_s = sync_q_r;
`endif

  // Previous echo level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_p <= 1'b0;
    end else begin
      echo_p <= echo_s;
    end
  end

  assign echo_rise  = echo_s & ~echo_p;
  assign echo_fall  = ~echo_s & echo_p;
  assign period_end = (period_r == PERIOD_LAST);

  // Free-running measurement period counter; its return to zero starts a cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_r <= '0;
    end else if (period_end) begin
      period_r <= '0;
    end else begin
      period_r <= period_r + PW'(1);
    end
  end

  // Next-state logic for the measurement sequencer.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (period_r == '0) state_n = ST_TRIG;
        else                state_n = ST_IDLE;
      end
      ST_TRIG: begin
        if (trig_cnt_r == TRIG_LAST) state_n = ST_WAIT;
        else                         state_n = ST_TRIG;
      end
      ST_WAIT: begin
        if (echo_rise)                      state_n = ST_MEAS;
        else if (wait_cnt_r == TIMEOUT_LAST) state_n = ST_DONE;
        else                                 state_n = ST_WAIT;
      end
      ST_MEAS: begin
        if (echo_fall || period_end) state_n = ST_DONE;
        else                         state_n = ST_MEAS;
      end
      ST_DONE: state_n = ST_PUB;
      ST_PUB:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Trigger-length and echo-wait counters, each running only in its own state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trig_cnt_r <= '0;
      wait_cnt_r <= '0;
    end else begin
      trig_cnt_r <= (state_r == ST_TRIG) ? trig_cnt_r + TW'(1) : '0;
      wait_cnt_r <= (state_r == ST_WAIT) ? wait_cnt_r + WW'(1) : '0;
    end
  end

  // Pulse-width measurement: CM_CLKS ticks per unit, saturating at 255; a
  // period expiring mid-pulse forces full scale unless the echo fell that clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_r <= '0;
      unit_r <= 8'd0;
    end else if (state_r == ST_WAIT && echo_rise) begin
      tick_r <= '0;
      unit_r <= 8'd0;
    end else if (state_r == ST_MEAS) begin
      if (period_end && !echo_fall) begin
        tick_r <= '0;
        unit_r <= 8'd255;
      end else if (tick_r == CM_LAST) begin
        tick_r <= '0;
        unit_r <= (unit_r == 8'd255) ? 8'd255 : unit_r + 8'd1;
      end else begin
        tick_r <= tick_r + CW'(1);
      end
    end else begin
      tick_r <= tick_r;
      unit_r <= unit_r;
    end
  end

  // Remember whether the wait phase ended without an echo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tflag_r <= 1'b0;
    end else if (state_r == ST_WAIT) begin
      tflag_r <= (state_n == ST_DONE);
    end else begin
      tflag_r <= tflag_r;
    end
  end

  // Registered outputs; count/timeout are loaded only when a result completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trigger   <= 1'b0;
      busy      <= 1'b0;
      calculate <= 1'b0;
      count     <= 8'd0;
      timeout   <= 1'b0;
    end else begin
      trigger   <= (state_n == ST_TRIG);
      busy      <= (state_n != ST_IDLE);
      calculate <= (state_r == ST_PUB);
      if (state_r == ST_DONE) begin
        count   <= tflag_r ? 8'd0 : unit_r;
        timeout <= tflag_r;
      end else begin
        count   <= count;
        timeout <= timeout;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_capture.sv
// Directed bench for ultrasonic_echo_capture with small timing parameters
// (TRIG 5, CM 10, TIMEOUT 500, PERIOD 4000 clocks).
module tb_ultrasonic_echo_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       echo = 1'b0;
  logic       trigger;
  logic [7:0] count;
  logic       calculate;
  logic       timeout;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int         calc_events = 0;
  int         long_pulses = 0;
  logic       calc_prev = 1'b0;
  logic [7:0] last_count = 8'd0;
  logic       last_timeout = 1'b0;

  typedef struct {
    bit         pre;
    bit         glitch;
    int         delay;
    int         width;
    logic [7:0] exp_count;
    bit         exp_timeout;
  } vec_t;

  vec_t vecs[8];

  ultrasonic_echo_capture #(
    .TRIG_CLKS(5), .CM_CLKS(10), .TIMEOUT_CLKS(500), .PERIOD_CLKS(4000)
  ) dut (
    .clk(clk), .reset(reset), .echo(echo), .trigger(trigger),
    .count(count), .calculate(calculate), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Record each calculate strobe and the result presented with it.
  always @(negedge clk) begin
    if (calculate) begin
      calc_events++;
      last_count   = count;
      last_timeout = timeout;
      if (calc_prev) long_pulses++;
    end
    calc_prev = calculate;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait for a trigger rise (bounded), then measure its width; optional echo
  // pulse fired while the trigger is high.
  task automatic wait_trigger(input string tag, input int bound, input bit pre,
                              output int waited, output int width);
    int i;
    bit seen;
    seen = 1'b0;
    for (i = 1; i <= bound; i++) begin
      tick();
      if (trigger) begin
        seen = 1'b1;
        break;
      end
    end
    waited = i;
    width  = 0;
    check({tag, " trigger_seen"}, int'(seen), 1);
    if (seen) begin
      check({tag, " busy_at_trigger"}, int'(busy), 1);
      if (pre) echo = 1'b1;
      width = 1;
      while (width < 20) begin
        tick();
        if (pre && width == 2) echo = 1'b0;
        if (!trigger) break;
        width++;
      end
      echo = 1'b0;
    end
  endtask

  task automatic wait_calc(input string tag, input int start, input int bound,
                           input int exp_count, input int exp_timeout);
    for (int i = 0; i < bound && calc_events == start; i++) tick();
    check({tag, " calc_pulses"}, calc_events - start, 1);
    check({tag, " count"}, int'(last_count), exp_count);
    check({tag, " timeout"}, int'(last_timeout), exp_timeout);
  endtask

  task automatic run_vec(input vec_t v, input string tag, output int trig_wait);
    int start, tw;
    start = calc_events;
    wait_trigger(tag, 9000, v.pre, trig_wait, tw);
    check({tag, " trigger_width"}, tw, 5);
    if (v.glitch) begin
      repeat (10) tick();
      echo = 1'b1;
      repeat (2) tick();
      echo = 1'b0;
    end
    if (v.width > 0) begin
      repeat (v.delay) tick();
      echo = 1'b1;
      repeat (v.width) tick();
      echo = 1'b0;
    end
    wait_calc(tag, start, 2000, int'(v.exp_count), int'(v.exp_timeout));
    tick();
    check({tag, " calc_after"}, int'(calculate), 0);
    check({tag, " busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int first_calc, tw, tl, start;

    //            pre   glitch delay width  count   tout
    vecs[0] = '{1'b0, 1'b0, 50,  200,  8'd20,  1'b0};
    vecs[1] = '{1'b0, 1'b0, 50,  10,   8'd1,   1'b0};
    vecs[2] = '{1'b0, 1'b0, 10,  9,    8'd0,   1'b0};
    vecs[3] = '{1'b0, 1'b0, 0,   0,    8'd0,   1'b1};
    vecs[4] = '{1'b1, 1'b0, 50,  60,   8'd6,   1'b0};
`ifdef ECHO_DEGLITCH_EN
    vecs[5] = '{1'b0, 1'b1, 50,  100,  8'd10,  1'b0};
`else
    vecs[5] = '{1'b0, 1'b1, 50,  100,  8'd0,   1'b0};
`endif
    vecs[6] = '{1'b0, 1'b0, 50,  3500, 8'd255, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 50,  129,  8'd12,  1'b0};

    // Reset state.
    repeat (3) tick();
    check("rst trigger", int'(trigger), 0);
    check("rst count", int'(count), 0);
    check("rst calculate", int'(calculate), 0);
    check("rst timeout", int'(timeout), 0);
    check("rst busy", int'(busy), 0);

    // First cycle after release: trigger clocks 1-5, timeout strobe at clock 508.
    reset = 1'b1;
    first_calc = 0;
    for (int n = 1; n <= 600; n++) begin
      tick();
      if (n <= 8) check($sformatf("first trigger clk%0d", n), int'(trigger), int'(n <= 5));
      if (n == 1) check("first busy", int'(busy), 1);
      if (calculate && first_calc == 0) first_calc = n;
    end
    check("first calc_clock", first_calc, 508);
    check("first count", int'(last_count), 0);
    check("first timeout", int'(last_timeout), 1);
    check("first calc_pulses", calc_events, 1);

    // Table-driven measurement periods.
    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k), tw);
    end

    // Reset in the middle of a 200-clock echo.
    start = calc_events;
    wait_trigger("midrst", 9000, 1'b0, tw, tl);
    repeat (50) tick();
    echo = 1'b1;
    repeat (100) tick();
    reset = 1'b0;
    #1;
    check("midrst trigger", int'(trigger), 0);
    check("midrst count", int'(count), 0);
    check("midrst calculate", int'(calculate), 0);
    check("midrst timeout", int'(timeout), 0);
    check("midrst busy", int'(busy), 0);
    echo = 1'b0;
    repeat (3) tick();
    check("midrst no_calc", calc_events - start, 0);
    reset = 1'b1;
    run_vec(vecs[0], "after_rst", tw);
    check("after_rst trigger_delay", tw, 1);

    // Echo still high at period end: full scale, then the next period starts
    // with echo already high and must time out.
    start = calc_events;
    wait_trigger("pend", 9000, 1'b0, tw, tl);
    repeat (50) tick();
    echo = 1'b1;
    wait_calc("pend", start, 5000, 255, 0);
    start = calc_events;
    wait_trigger("held", 9000, 1'b0, tw, tl);
    repeat (20) tick();
    echo = 1'b0;
    wait_calc("held", start, 1000, 0, 1);

    check("calc_width", long_pulses, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_capture.md
# ultrasonic_echo_capture

Front-end stage of the ultrasonic range-finder path: periodically fires the sensor trigger, measures the echo pulse width in centimetre units, and presents an 8-bit `count` with a `calculate` strobe to the downstream divider/BCD/display chain. Runs on the board clock, free-running after reset. One measurement per cycle period; the last result is held until the next one completes.

## Interface
Parameters:
- `TRIG_CLKS`, 500: trigger high time in clocks (10 µs at 50 MHz).
- `CM_CLKS`, 2900: clocks per count unit (58 µs per cm at 50 MHz).
- `TIMEOUT_CLKS`, 1_500_000: max wait for echo rise after trigger falls.
- `PERIOD_CLKS`, 3_000_000: measurement cycle length, trigger rise to trigger rise (60 ms).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `echo`  in  1  sensor echo, asynchronous to `clk`.
- `trigger`  out  1  sensor trigger pulse.
- `count`  out  8  last measured distance, cm, saturating at 255.
- `calculate`  out  1  one-clock strobe: `count` is new and stable.
- `timeout`  out  1  last cycle had no echo; valid with `calculate`.
- `busy`  out  1  high from trigger rise until result published.

## Operation
- `echo` passes a 2-flop synchronizer; edges detected on synchronized value (`echo_s`, previous `echo_p`).
- Period counter: counts 0..PERIOD_CLKS-1, wraps, independent of FSM; wrap to 0 starts a cycle.
- FSM states:
  - IDLE: `trigger`=0, `busy`=0. On period counter = 0 → TRIG.
  - TRIG: `trigger`=1 for exactly TRIG_CLKS clocks → WAIT.
  - WAIT: wait counter runs. Rising `echo_s` → MEAS (tick and unit counters cleared). Wait counter reaches TIMEOUT_CLKS-1 → DONE with timeout.
  - MEAS: tick counter 0..CM_CLKS-1; on wrap, unit counter +1, saturating at 255. Falling `echo_s` → DONE. Period counter reaching PERIOD_CLKS-1 while in MEAS → DONE, unit = 255.
  - DONE: register `count` ← unit (0 on timeout), `timeout` ← flag; next clock `calculate`=1 for one clock → IDLE.
- Partial final tick truncated (floor): echo of 2.9 units reports 2.
- Echo already high when entering WAIT is not a rising edge; must see low then high.
- `count` and `timeout` change only in DONE; hold otherwise.

## Timing
- Reset values: `trigger`=0, `count`=0, `calculate`=0, `timeout`=0, `busy`=0, FSM=IDLE, all counters 0. First trigger rises on the first clock after reset release (period counter 0).
- `trigger` registered; high exactly TRIG_CLKS clocks.
- Echo edge latency: 2 clocks sync + 1 clock detect.
- Echo fall seen → DONE next clock → `count` updated the following clock → `calculate` high one clock later; `count` stable from one clock before `calculate` until next DONE.
- Echo fall and period end same clock: treat as echo fall (normal unit value).
- Reset mid-measurement: immediate abort, all outputs to reset values, no `calculate`.
- Pulses of `echo` during IDLE/TRIG ignored.

## Configuration
- `ECHO_DEGLITCH_EN`: defined → `echo_s` replaced by a 4-clock majority-free filter: filtered level changes only after 4 consecutive equal synchronized samples (adds 4 clocks edge latency, rejects pulses < 4 clocks). Undefined → 2-flop synchronizer only, any pulse ≥1 clock is accepted.

## Test plan
Sim parameters: TRIG_CLKS=5, CM_CLKS=10, TIMEOUT_CLKS=500, PERIOD_CLKS=4000.
- Reset release, echo low → `trigger` high clocks 1–5, no `calculate` until clock ~505, then `calculate` with `count`=0, `timeout`=1.
- Echo high 200 clocks starting 50 clocks after trigger fall → `count`=20, `timeout`=0, one `calculate` pulse per period.
- Echo high 129 clocks → `count`=12 (truncation).
- Echo held high 3500 clocks → `count`=255, no wrap, `timeout`=0.
- Reset asserted at clock 100 of a 200-clock echo → all outputs 0 immediately; after release, fresh trigger and correct next result.
- With `ECHO_DEGLITCH_EN`: 2-clock echo glitch then 100-clock echo → `count`=10; without macro glitch is measured → `count`=0 on first cycle.
